// File: rtl/uart_frame_pkg.sv
// Shared constants and state types for the telemetry frame receiver.
// Frame format: 'A' dddd 'B' dddd 'C' (ASCII, 8N1).
package uart_frame_pkg;

    localparam logic [7:0] CH_A = 8'd65;
    localparam logic [7:0] CH_B = 8'd66;
    localparam logic [7:0] CH_C = 8'd67;
    localparam logic [7:0] CH_0 = 8'd48;
    localparam logic [7:0] CH_9 = 8'd57;

    localparam int FRAME_DIGITS = 4;

    typedef enum logic [2:0] {
        P_IDLE,
        P_KDIG,
        P_B,
        P_PDIG,
        P_C
    } p_state_t;

    typedef enum logic [2:0] {
        R_IDLE,
        R_START,
        R_DATA,
        R_STOP,
        R_WAIT
    } r_state_t;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= CH_0) && (b <= CH_9);
    endfunction

endpackage

// File: rtl/uart_frame_rx_byte.sv
// 8N1 byte receiver: 2-FF synchroniser, falling-edge start detect,
// mid-bit sampling driven by a baud counter.
module uart_byte_rx
    import uart_frame_pkg::*;
#(
    parameter int CLK_FRE = 50_000_000,
    parameter int BAUD    = 115_200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rxd,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       stop_err
);

    localparam int BAUD_DIV = CLK_FRE / BAUD;
    localparam int HALF_DIV = BAUD_DIV / 2;
    localparam int CW       = $clog2(BAUD_DIV);

    logic          rxd_s1;
    logic          rxd_s2;
    logic          rxd_prev;
    logic          fall;
    r_state_t      state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;

    assign fall = rxd_prev & ~rxd_s2;

    // Synchronise the asynchronous line and keep one extra stage for edge detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_s1   <= 1'b1;
            rxd_s2   <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rxd_s1   <= uart_rxd;
            rxd_s2   <= rxd_s1;
            rxd_prev <= rxd_s2;
        end
    end

    // Byte FSM: confirm start at half bit, then sample data and stop once per bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= R_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            byte_data  <= '0;
            byte_valid <= 1'b0;
            stop_err   <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            stop_err   <= 1'b0;
            unique case (state)
                R_IDLE: begin
                    cnt <= '0;
                    if (fall) state <= R_START;
                end
                R_START: begin
                    if (cnt == CW'(HALF_DIV - 1)) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rxd_s2 ? R_IDLE : R_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                R_DATA: begin
                    if (cnt == CW'(BAUD_DIV - 1)) begin
                        cnt   <= '0;
                        shreg <= {rxd_s2, shreg[7:1]};
                        if (bit_idx == 3'd7) state <= R_STOP;
                        else bit_idx <= bit_idx + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                R_STOP: begin
                    if (cnt == CW'(BAUD_DIV - 1)) begin
                        cnt <= '0;
                        if (rxd_s2) begin
                            byte_valid <= 1'b1;
                            byte_data  <= shreg;
                            state      <= R_IDLE;
                        end else begin
                            stop_err <= 1'b1;
                            state    <= R_WAIT;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                R_WAIT: begin
                    // A low stop bit may be a break; do not treat it as a new start edge.
                    if (rxd_s2) state <= R_IDLE;
                end
                default: state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_frame_rx.sv
// Telemetry frame receiver: parses 'A' dddd 'B' dddd 'C' into two binary
// fields. Optional inter-byte timeout enabled by defining RX_TIMEOUT_EN.
module uart_frame_rx
    import uart_frame_pkg::*;
#(
    parameter int CLK_FRE     = 50_000_000,
    parameter int BAUD        = 115_200,
    parameter int TIMEOUT_CYC = 20 * (CLK_FRE / BAUD)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        uart_rxd,
    output logic [14:0] data_k,
    output logic [14:0] period_time,
    output logic        frame_valid,
    output logic        frame_err
);

    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        stop_err;
    p_state_t    state;
    logic [14:0] acc;
    logic [14:0] k_hold;
    logic [2:0]  dig;
    logic [14:0] acc_next;
    logic        byte_ok;
    logic        last_dig;
    logic        gap_hit;

    uart_byte_rx #(
        .CLK_FRE(CLK_FRE),
        .BAUD   (BAUD)
    ) u_byte_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .uart_rxd  (uart_rxd),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .stop_err  (stop_err)
    );

    // Decimal accumulate and per-state byte acceptance; low nibble of an ASCII digit is its value.
    always_comb begin
        acc_next = (acc << 3) + (acc << 1) + {11'd0, byte_data[3:0]};
        last_dig = (dig == 3'(FRAME_DIGITS - 1));
        byte_ok  = 1'b0;
        unique case (state)
            P_IDLE:         byte_ok = 1'b1;
            P_KDIG, P_PDIG: byte_ok = is_digit(byte_data);
            P_B:            byte_ok = (byte_data == CH_B);
            P_C:            byte_ok = (byte_data == CH_C);
            default:        byte_ok = 1'b0;
        endcase
    end

`ifdef RX_TIMEOUT_EN
    logic [31:0] gap;

    assign gap_hit = (gap == 32'(TIMEOUT_CYC));

    // Idle-gap counter, only live while a frame is in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap <= '0;
        end else if (byte_valid || stop_err || state == P_IDLE) begin
            gap <= '0;
        end else if (!gap_hit) begin
            gap <= gap + 1'b1;
        end
    end
`else
    assign gap_hit = 1'b0;
`endif

    // Frame parser with registered field outputs and single-cycle strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= P_IDLE;
            acc         <= '0;
            k_hold      <= '0;
            dig         <= '0;
            data_k      <= '0;
            period_time <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            if (stop_err) begin
                frame_err <= 1'b1;
                state     <= P_IDLE;
            end else if (byte_valid && !byte_ok) begin
                frame_err <= 1'b1;
                if (byte_data == CH_A) begin
                    acc   <= '0;
                    dig   <= '0;
                    state <= P_KDIG;
                end else begin
                    state <= P_IDLE;
                end
            end else if (byte_valid) begin
                unique case (state)
                    P_IDLE: begin
                        if (byte_data == CH_A) begin
                            acc   <= '0;
                            dig   <= '0;
                            state <= P_KDIG;
                        end
                    end
                    P_KDIG, P_PDIG: begin
                        acc <= acc_next;
                        if (last_dig) begin
                            dig   <= '0;
                            state <= (state == P_KDIG) ? P_B : P_C;
                        end else begin
                            dig <= dig + 1'b1;
                        end
                    end
                    P_B: begin
                        k_hold <= acc;
                        acc    <= '0;
                        dig    <= '0;
                        state  <= P_PDIG;
                    end
                    P_C: begin
                        data_k      <= k_hold;
                        period_time <= acc;
                        frame_valid <= 1'b1;
                        state       <= P_IDLE;
                    end
                    default: state <= P_IDLE;
                endcase
            end else if (gap_hit && state != P_IDLE) begin
                frame_err <= 1'b1;
                state     <= P_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Self-checking bench for uart_frame_rx. Reduced clock/baud ratio (16 clk/bit)
// keeps runtime short. Timeout expectations follow RX_TIMEOUT_EN.
module tb_uart_frame_rx;

    localparam int CLK_FRE = 1_600_000;
    localparam int BAUD    = 100_000;
    localparam int BIT     = CLK_FRE / BAUD;
    localparam int TOUT    = 20 * BIT;

    localparam logic [7:0] KA = 8'h41;
    localparam logic [7:0] KB = 8'h42;
    localparam logic [7:0] KC = 8'h43;
    localparam logic [7:0] K0 = 8'h30;
    localparam logic [7:0] K9 = 8'h39;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        uart_rxd = 1'b1;
    logic [14:0] data_k;
    logic [14:0] period_time;
    logic        frame_valid;
    logic        frame_err;

    int          checks = 0;
    int          errors = 0;
    string       obs_s = "";
    string       exp_s = "";
    logic [7:0]  mbuf[$];
    int          last_k = 0;
    int          last_p = 0;

    uart_frame_rx #(
        .CLK_FRE    (CLK_FRE),
        .BAUD       (BAUD),
        .TIMEOUT_CYC(TOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .uart_rxd   (uart_rxd),
        .data_k     (data_k),
        .period_time(period_time),
        .frame_valid(frame_valid),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    // Record every strobe as a compact event string; strobes must never coincide.
    always @(negedge clk) begin
        if (rst_n && (frame_valid || frame_err)) begin
            checks++;
            if (frame_valid && frame_err) begin
                errors++;
                $display("FAIL pulse_exclusive got valid=1 err=1 want at most one");
            end
            if (frame_valid) obs_s = {obs_s, $sformatf("V%0d/%0d;", data_k, period_time)};
            if (frame_err) obs_s = {obs_s, "E;"};
        end
    end

    // Reference: a frame is the 11-byte pattern; a byte is judged by its position in the pending frame.
    function automatic void model_byte(input logic [7:0] b, input bit bad_stop);
        int pos;
        bit ok;
        int k;
        int p;
        if (bad_stop) begin
            exp_s = {exp_s, "E;"};
            mbuf.delete();
            return;
        end
        pos = mbuf.size();
        if (pos == 0) begin
            if (b == KA) mbuf.push_back(b);
            return;
        end
        if (pos == 5) ok = (b == KB);
        else if (pos == 10) ok = (b == KC);
        else ok = (b >= K0) && (b <= K9);
        if (!ok) begin
            exp_s = {exp_s, "E;"};
            mbuf.delete();
            if (b == KA) mbuf.push_back(b);
            return;
        end
        mbuf.push_back(b);
        if (mbuf.size() == 11) begin
            k = 0;
            p = 0;
            for (int i = 1; i <= 4; i++) begin
                k = k * 10 + int'(mbuf[i]) - 48;
                p = p * 10 + int'(mbuf[i + 5]) - 48;
            end
            last_k = k;
            last_p = p;
            exp_s = {exp_s, $sformatf("V%0d/%0d;", k, p)};
            mbuf.delete();
        end
    endfunction

    function automatic void model_timeout();
        if (mbuf.size() != 0) begin
            exp_s = {exp_s, "E;"};
            mbuf.delete();
        end
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit bad_stop, input int gap_bits);
        uart_rxd = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            repeat (BIT) @(negedge clk);
        end
        uart_rxd = !bad_stop;
        repeat (BIT) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (gap_bits * BIT) @(negedge clk);
        model_byte(b, bad_stop);
    endtask

    task automatic send_str(input string s, input int bad_idx, input int gap_bits);
        for (int i = 0; i < s.len(); i++)
            send_byte(s[i], i == bad_idx, (i == bad_idx && gap_bits < 1) ? 1 : gap_bits);
    endtask

    task automatic drain();
        repeat (4 * BIT) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (data_k !== 15'd0) begin errors++; $display("FAIL rst_data_k got %0d want 0", data_k); end
        checks++; if (period_time !== 15'd0) begin errors++; $display("FAIL rst_period got %0d want 0", period_time); end
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", frame_valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", frame_err); end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (data_k !== 15'd0) begin errors++; $display("FAIL post_rst_data_k got %0d want 0", data_k); end
    endtask

    task automatic test_nominal();
        obs_s = ""; exp_s = "";
        send_str("A1234B0567C", -1, 1);
        drain();
        checks++; if (obs_s != exp_s) begin errors++; $display("FAIL nominal_events got %s want %s", obs_s, exp_s); end
        checks++; if (data_k !== 15'(last_k)) begin errors++; $display("FAIL nominal_data_k got %0d want %0d", data_k, last_k); end
        checks++; if (period_time !== 15'(last_p)) begin errors++; $display("FAIL nominal_period got %0d want %0d", period_time, last_p); end
    endtask

    task automatic test_bad_digit();
        obs_s = ""; exp_s = "";
        send_str("A0001B0002C", -1, 1);
        send_str("A12X4B0567C", -1, 1);
        drain();
        checks++; if (obs_s != exp_s) begin errors++; $display("FAIL bad_digit_events got %s want %s", obs_s, exp_s); end
        checks++; if (data_k !== 15'(last_k)) begin errors++; $display("FAIL bad_digit_data_k got %0d want %0d", data_k, last_k); end
        checks++; if (period_time !== 15'(last_p)) begin errors++; $display("FAIL bad_digit_period got %0d want %0d", period_time, last_p); end
    endtask

    task automatic test_back_to_back_resync();
        obs_s = ""; exp_s = "";
        send_str("A12A5678B9999C", -1, 0);
        drain();
        checks++; if (obs_s != exp_s) begin errors++; $display("FAIL resync_events got %s want %s", obs_s, exp_s); end
        checks++; if (data_k !== 15'(last_k)) begin errors++; $display("FAIL resync_data_k got %0d want %0d", data_k, last_k); end
        checks++; if (period_time !== 15'(last_p)) begin errors++; $display("FAIL resync_period got %0d want %0d", period_time, last_p); end
    endtask

    task automatic test_stop_err();
        obs_s = ""; exp_s = "";
        send_str("A1111B2222C", 3, 1);
        send_str("A0042B0100C", -1, 1);
        drain();
        checks++; if (obs_s != exp_s) begin errors++; $display("FAIL stop_err_events got %s want %s", obs_s, exp_s); end
        checks++; if (data_k !== 15'(last_k)) begin errors++; $display("FAIL stop_err_data_k got %0d want %0d", data_k, last_k); end
        checks++; if (period_time !== 15'(last_p)) begin errors++; $display("FAIL stop_err_period got %0d want %0d", period_time, last_p); end
    endtask

    task automatic test_reset_mid();
        obs_s = ""; exp_s = "";
        send_str("A12", -1, 1);
        rst_n = 1'b0;
        mbuf.delete();
        last_k = 0;
        last_p = 0;
        repeat (5) @(negedge clk);
        checks++; if (data_k !== 15'd0) begin errors++; $display("FAIL mid_rst_data_k got %0d want 0", data_k); end
        checks++; if (period_time !== 15'd0) begin errors++; $display("FAIL mid_rst_period got %0d want 0", period_time); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        send_str("A3000B4000C", -1, 1);
        drain();
        checks++; if (obs_s != exp_s) begin errors++; $display("FAIL mid_rst_events got %s want %s", obs_s, exp_s); end
        checks++; if (data_k !== 15'(last_k)) begin errors++; $display("FAIL mid_rst_data_k2 got %0d want %0d", data_k, last_k); end
        checks++; if (period_time !== 15'(last_p)) begin errors++; $display("FAIL mid_rst_period2 got %0d want %0d", period_time, last_p); end
    endtask

    task automatic test_glitch();
        obs_s = ""; exp_s = "";
        uart_rxd = 1'b0;
        repeat (100) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (20 * BIT) @(negedge clk);
        uart_rxd = 1'b0;
        repeat (3) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (4 * BIT) @(negedge clk);
        checks++; if (obs_s != exp_s) begin errors++; $display("FAIL glitch_events got %s want %s", obs_s, exp_s); end
        send_str("A0314B2718C", -1, 1);
        drain();
        checks++; if (obs_s != exp_s) begin errors++; $display("FAIL glitch_frame_events got %s want %s", obs_s, exp_s); end
        checks++; if (data_k !== 15'(last_k)) begin errors++; $display("FAIL glitch_data_k got %0d want %0d", data_k, last_k); end
    endtask

    task automatic test_random();
        string      s;
        logic [7:0] fb[11];
        int         bad;
        int         pos;
        obs_s = ""; exp_s = "";
        for (int f = 0; f < 8; f++) begin
            s = $sformatf("A%04dB%04dC", $urandom_range(0, 9999), $urandom_range(0, 9999));
            for (int i = 0; i < 11; i++) fb[i] = s[i];
            bad = -1;
            if (f < 7 && $urandom_range(0, 3) == 0) begin
                pos = $urandom_range(0, 10);
                fb[pos] = 8'($urandom_range(32, 126));
            end
            if (f < 7 && $urandom_range(0, 5) == 0) bad = $urandom_range(0, 10);
            for (int i = 0; i < 11; i++)
                send_byte(fb[i], i == bad, (i == bad) ? 1 : $urandom_range(0, 2));
        end
        drain();
        checks++; if (obs_s != exp_s) begin errors++; $display("FAIL random_events got %s want %s", obs_s, exp_s); end
        checks++; if (data_k !== 15'(last_k)) begin errors++; $display("FAIL random_data_k got %0d want %0d", data_k, last_k); end
        checks++; if (period_time !== 15'(last_p)) begin errors++; $display("FAIL random_period got %0d want %0d", period_time, last_p); end
    endtask

    task automatic test_timeout();
        obs_s = ""; exp_s = "";
        send_str("A123", -1, 1);
        repeat (TOUT + 200) @(negedge clk);
`ifdef RX_TIMEOUT_EN
        model_timeout();
`endif
        checks++; if (obs_s != exp_s) begin errors++; $display("FAIL timeout_gap_events got %s want %s", obs_s, exp_s); end
        send_str("A0007B0008C", -1, 1);
        drain();
        checks++; if (obs_s != exp_s) begin errors++; $display("FAIL timeout_events got %s want %s", obs_s, exp_s); end
        checks++; if (data_k !== 15'(last_k)) begin errors++; $display("FAIL timeout_data_k got %0d want %0d", data_k, last_k); end
        checks++; if (period_time !== 15'(last_p)) begin errors++; $display("FAIL timeout_period got %0d want %0d", period_time, last_p); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_nominal();
        test_bad_digit();
        test_back_to_back_resync();
        test_stop_err();
        test_reset_mid();
        test_glitch();
        test_random();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
